rx_data_sampler: RTL and testbench



---
 rtl/rx_data_sampler_pkg.sv | 14 +
 rtl/rx_data_sampler_if.sv | 26 ++
 rtl/rx_data_sampler_edge_bit_counter.sv | 73 +++++++
 rtl/rx_data_sampler.sv | 80 ++++++++
 tb/tb_rx_data_sampler.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/rx_data_sampler_pkg.sv
// Shared definitions for the UART RX front end: legal oversampling ratios,
// the default frame length and the 2-of-3 bit vote.
package uart_rx_pkg;

   localparam int PRESC_8        = 8;
   localparam int PRESC_16       = 16;
   localparam int PRESC_32       = 32;
   localparam int FRAME_BITS_MAX = 11;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_data_sampler_if.sv
// Bundle between the RX FSM / line side and the oversampling front end.
interface rx_data_sampler_if #(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
);

   logic                  rx_in;
   logic [PRESCALE_W-1:0] prescale;
   logic                  smp_en;
   logic                  sampled_bit;
   logic                  done;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  bit_end;

   modport master (
      output rx_in, prescale, smp_en,
      input  sampled_bit, done, edge_cnt, bit_cnt, bit_end
   );

   modport slave (
      input  rx_in, prescale, smp_en,
      output sampled_bit, done, edge_cnt, bit_cnt, bit_end
   );

endinterface

// File: rtl/rx_data_sampler_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter, with the prescale value
// captured once at the start of each frame.
module edge_bit_counter
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  smp_en,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  bit_end,
   output logic [PRESCALE_W-1:0] half,
   output logic                  active
);

   logic [PRESCALE_W-1:0] p_reg;
   logic [PRESCALE_W-1:0] p_dec;
   logic [PRESCALE_W-1:0] p_last;
   logic                  smp_en_q;
   logic                  rise;

   always_comb begin
      p_dec = PRESCALE_W'(PRESC_8);
      if (prescale == PRESCALE_W'(PRESC_16)) begin
         p_dec = PRESCALE_W'(PRESC_16);
      end else if (prescale == PRESCALE_W'(PRESC_32)) begin
         p_dec = PRESCALE_W'(PRESC_32);
      end
   end

   assign p_last  = p_reg - PRESCALE_W'(1);
   assign half    = p_reg >> 1;
   assign rise    = smp_en & ~smp_en_q;
   assign bit_end = smp_en & active & (edge_cnt == p_last);

   // smp_en_q resets high so that an smp_en held high through reset is not
   // mistaken for a new frame; a genuine 0->1 is needed to start counting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_reg    <= PRESCALE_W'(PRESC_8);
         smp_en_q <= 1'b1;
         active   <= 1'b0;
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         smp_en_q <= smp_en;
         if (!smp_en) begin
            active   <= 1'b0;
            edge_cnt <= '0;
            bit_cnt  <= '0;
         end else if (rise) begin
            active   <= 1'b1;
            p_reg    <= p_dec;
            edge_cnt <= '0;
            bit_cnt  <= '0;
         end else if (active) begin
            if (edge_cnt == p_last) begin
               edge_cnt <= '0;
               if (bit_cnt != {BIT_CNT_W{1'b1}}) begin
                  bit_cnt <= bit_cnt + BIT_CNT_W'(1);
               end
            end else begin
               edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/rx_data_sampler.sv
// UART RX oversampling front end: three samples around each bit centre,
// a 2-of-3 vote, and a one-cycle done strobe carrying the result.
module rx_data_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   rx_data_sampler_if.slave bus
);

   logic [PRESCALE_W-1:0] edge_cnt;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic [PRESCALE_W-1:0] half;
   logic [PRESCALE_W-1:0] half_m1;
   logic [PRESCALE_W-1:0] half_m2;
   logic                  bit_end;
   logic                  active;
   logic                  run;
   logic                  s0;
   logic                  s1;
   logic                  sampled_bit;
   logic                  done;

   edge_bit_counter #(
      .PRESCALE_W (PRESCALE_W),
      .BIT_CNT_W  (BIT_CNT_W)
   ) counter (
      .clk      (clk),
      .rst      (rst),
      .smp_en   (bus.smp_en),
      .prescale (bus.prescale),
      .edge_cnt (edge_cnt),
      .bit_cnt  (bit_cnt),
      .bit_end  (bit_end),
      .half     (half),
      .active   (active)
   );

   assign half_m1 = half - PRESCALE_W'(1);
   assign half_m2 = half - PRESCALE_W'(2);
   assign run     = bus.smp_en & active;

   // Gating on smp_en at the decision edge is what suppresses done when the
   // frame is abandoned exactly at the bit centre.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0          <= 1'b0;
         s1          <= 1'b0;
         sampled_bit <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!run) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
         end else begin
            if (edge_cnt == half_m2) begin
               s0 <= bus.rx_in;
            end
            if (edge_cnt == half_m1) begin
               s1 <= bus.rx_in;
            end
            if (edge_cnt == half) begin
               sampled_bit <= maj3(s0, s1, bus.rx_in);
               done        <= 1'b1;
            end
         end
      end
   end

   assign bus.sampled_bit = sampled_bit;
   assign bus.done        = done;
   assign bus.edge_cnt    = edge_cnt;
   assign bus.bit_cnt     = bit_cnt;
   assign bus.bit_end     = bit_end;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Directed bench for rx_data_sampler: single-bit vote vectors from a table,
// plus hand-written frame, prescale, reset and abort sequences.
module tb_rx_data_sampler;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rx_data_sampler_if #(.PRESCALE_W(6), .BIT_CNT_W(4)) bus ();

   rx_data_sampler #(
      .PRESCALE_W (6),
      .BIT_CNT_W  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         p;
      int         eff_p;
      logic       bg;
      logic [2:0] smp;
      logic       exp_bit;
   } vec_t;

   vec_t vecs[10];
   int   n_checks = 0;
   int   n_fails  = 0;
   logic last_bit = 1'b0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic startFrame(input int p);
      @(negedge clk);
      bus.prescale = 6'(p);
      bus.smp_en   = 1'b1;
      @(posedge clk);
   endtask

   task automatic stopFrame();
      @(negedge clk);
      bus.smp_en = 1'b0;
      @(posedge clk);
   endtask

   // One bit per vector: smp holds the line value at H-2, H-1 and H.
   task automatic applyStimulus(input int i);
      int h;
      h = vecs[i].eff_p / 2;
      startFrame(vecs[i].p);
      for (int e = 0; e < vecs[i].eff_p; e++) begin
         @(negedge clk);
         checkOutput($sformatf("vec%0d edge_cnt", i), int'(bus.edge_cnt), e);
         checkOutput($sformatf("vec%0d bit_end", i), int'(bus.bit_end), int'(e == vecs[i].eff_p - 1));
         checkOutput($sformatf("vec%0d done", i), int'(bus.done), int'(e == h + 1));
         if (e == h + 1) begin
            checkOutput($sformatf("vec%0d sampled_bit", i), int'(bus.sampled_bit), int'(vecs[i].exp_bit));
            last_bit = vecs[i].exp_bit;
         end
         if (e == h - 2)      bus.rx_in = vecs[i].smp[0];
         else if (e == h - 1) bus.rx_in = vecs[i].smp[1];
         else if (e == h)     bus.rx_in = vecs[i].smp[2];
         else                 bus.rx_in = vecs[i].bg;
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d wrap edge_cnt", i), int'(bus.edge_cnt), 0);
      checkOutput($sformatf("vec%0d wrap bit_cnt", i), int'(bus.bit_cnt), 1);
      stopFrame();
   endtask

   task automatic runFrame(input int p, input int eff_p, input logic [31:0] bits,
                           input int nbits, input int new_p);
      int h;
      int dones;
      h     = eff_p / 2;
      dones = 0;
      startFrame(p);
      for (int b = 0; b < nbits; b++) begin
         for (int e = 0; e < eff_p; e++) begin
            @(negedge clk);
            checkOutput($sformatf("P%0d b%0d e%0d edge_cnt", p, b, e), int'(bus.edge_cnt), e);
            checkOutput($sformatf("P%0d b%0d e%0d bit_cnt", p, b, e), int'(bus.bit_cnt), (b > 15) ? 15 : b);
            checkOutput($sformatf("P%0d b%0d e%0d bit_end", p, b, e), int'(bus.bit_end), int'(e == eff_p - 1));
            checkOutput($sformatf("P%0d b%0d e%0d done", p, b, e), int'(bus.done), int'(e == h + 1));
            if (bus.done) dones++;
            if (e == h + 1) begin
               checkOutput($sformatf("P%0d b%0d sampled_bit", p, b), int'(bus.sampled_bit), int'(bits[b]));
               last_bit = bits[b];
            end
            if (new_p != 0 && b == 1 && e == 3) bus.prescale = 6'(new_p);
            bus.rx_in = bits[b];
         end
      end
      @(negedge clk);
      checkOutput($sformatf("P%0d end edge_cnt", p), int'(bus.edge_cnt), 0);
      checkOutput($sformatf("P%0d end bit_cnt", p), int'(bus.bit_cnt), (nbits > 15) ? 15 : nbits);
      checkOutput($sformatf("P%0d done count", p), dones, nbits);
      stopFrame();
   endtask

   task automatic checkIdle(input string tag, input int exp_sampled);
      checkOutput({tag, " edge_cnt"}, int'(bus.edge_cnt), 0);
      checkOutput({tag, " bit_cnt"}, int'(bus.bit_cnt), 0);
      checkOutput({tag, " done"}, int'(bus.done), 0);
      checkOutput({tag, " bit_end"}, int'(bus.bit_end), 0);
      checkOutput({tag, " sampled_bit"}, int'(bus.sampled_bit), exp_sampled);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{p: 8,  eff_p: 8,  bg: 1'b0, smp: 3'b000, exp_bit: 1'b0};
      vecs[1] = '{p: 8,  eff_p: 8,  bg: 1'b0, smp: 3'b111, exp_bit: 1'b1};
      vecs[2] = '{p: 16, eff_p: 16, bg: 1'b1, smp: 3'b101, exp_bit: 1'b1};
      vecs[3] = '{p: 16, eff_p: 16, bg: 1'b1, smp: 3'b100, exp_bit: 1'b0};
      vecs[4] = '{p: 32, eff_p: 32, bg: 1'b0, smp: 3'b011, exp_bit: 1'b1};
      vecs[5] = '{p: 32, eff_p: 32, bg: 1'b1, smp: 3'b010, exp_bit: 1'b0};
      vecs[6] = '{p: 8,  eff_p: 8,  bg: 1'b1, smp: 3'b001, exp_bit: 1'b0};
      vecs[7] = '{p: 12, eff_p: 8,  bg: 1'b0, smp: 3'b110, exp_bit: 1'b1};
      vecs[8] = '{p: 16, eff_p: 16, bg: 1'b0, smp: 3'b110, exp_bit: 1'b1};
      vecs[9] = '{p: 40, eff_p: 8,  bg: 1'b1, smp: 3'b000, exp_bit: 1'b0};

      rst          = 1'b0;
      bus.smp_en   = 1'b0;
      bus.rx_in    = 1'b0;
      bus.prescale = 6'd8;
      repeat (2) @(negedge clk);
      checkIdle("reset", 0);
      rst = 1'b1;

      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         bus.rx_in = ~bus.rx_in;
         checkIdle("idle", 0);
      end

      for (int i = 0; i < 10; i++) begin
         applyStimulus(i);
      end

      runFrame(8, 8, 32'b10, 2, 0);
      runFrame(32, 32, 32'b100_1010_1010, 11, 0);
      runFrame(16, 16, 32'b101, 3, 8);
      runFrame(12, 8, 32'b01, 2, 0);
      runFrame(8, 8, 32'h0001_5A3C, 17, 0);

      // Async reset in the middle of bit 3, before its decision edge.
      startFrame(8);
      bus.rx_in = 1'b1;
      for (int k = 0; k <= 28; k++) @(negedge clk);
      checkOutput("pre-reset edge_cnt", int'(bus.edge_cnt), 4);
      checkOutput("pre-reset bit_cnt", int'(bus.bit_cnt), 3);
      checkOutput("pre-reset sampled_bit", int'(bus.sampled_bit), 1);
      rst = 1'b0;
      #1;
      checkIdle("async reset", 0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkIdle("held smp_en after reset", 0);
      end
      stopFrame();
      runFrame(8, 8, 32'b10, 2, 0);

      // smp_en drops exactly on the decision edge of a P=16 bit.
      startFrame(16);
      for (int e = 0; e <= 8; e++) begin
         @(negedge clk);
         checkOutput($sformatf("abort e%0d edge_cnt", e), int'(bus.edge_cnt), e);
         bus.rx_in = ~last_bit;
         if (e == 8) bus.smp_en = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkIdle("abort", int'(last_bit));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
